mem_req_ctrl: RTL and testbench
===============================

Name: mem_req_ctrl

Overview:
Memory request controller directly upstream of the memory-response skid buffer in the load/store path. It arbitrates round-robin among NUM_REQ LSU request ports and issues one request at a time to the external memory port. It captures the read response and presents it as a single-cycle m_rsp_vld/m_rsp_data pulse, with the requester ID, for the skid buffer to absorb. Only one request is outstanding at a time, so the one-entry skid buffer can never be overrun.

Parameters:
- NUM_REQ, 4, number of LSU requester ports (power of two, ≥2)
- ID_W, 2, width of requester ID; equals $clog2(NUM_REQ)
- DATA_WIDTH, from constants_pkg (8), data width
- ADDR_WIDTH, from constants_pkg (8), address width
- TIMEOUT_CYCLES, 64, response watchdog limit; used only with MEM_RSP_TIMEOUT_EN

Ports:
- clk  input  1  clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- lsu_req_vld  input  NUM_REQ  per-port request valid
- lsu_req_we  input  NUM_REQ  per-port write enable (1 = write, 0 = read)
- lsu_req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- lsu_req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data, same packing as lsu_req_addr
- lsu_req_rdy  output  NUM_REQ  one-hot accept pulse
- mem_req_vld  output  1  memory request valid
- mem_req_we  output  1  memory write enable
- mem_req_addr  output  ADDR_WIDTH  memory address
- mem_req_wdata  output  DATA_WIDTH  memory write data
- mem_req_rdy  input  1  memory accepts request
- mem_rsp_vld  input  1  memory read data valid; no backpressure
- mem_rsp_data  input  DATA_WIDTH  memory read data
- m_rsp_vld  output  1  response pulse to skid buffer
- m_rsp_data  output  DATA_WIDTH  response data
- m_rsp_id  output  ID_W  requester ID of the response
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: synchronous, active-high; it aborts any operation in progress.
  - Next edge: state = IDLE, rr_ptr = 0.
  - All outputs 0: m_rsp_vld, m_rsp_data, m_rsp_id, mem_req_*, lsu_req_rdy, busy.
  - An in-flight memory response arriving after reset is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any lsu_req_vld bit is set, grant the first set bit scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  - In that same cycle: lsu_req_rdy[g] = 1 (combinational from the grant); latch we, addr, wdata and g; go to ISSUE.
  - If no bit is set, stay in IDLE.
- ISSUE:
  - mem_req_vld = 1 and mem_req_* driven from the latched values, held stable until mem_req_rdy.
  - On mem_req_rdy with a write: request complete, no response generated; rr_ptr = g+1 mod NUM_REQ; go to IDLE.
  - On mem_req_rdy with a read: go to WAIT.
- WAIT:
  - On mem_rsp_vld, register mem_rsp_data and go to RESP.
  - mem_rsp_vld in any other state is ignored.
- RESP:
  - m_rsp_vld = 1 for exactly one cycle, with m_rsp_data = captured data and m_rsp_id = g.
  - rr_ptr = g+1 mod NUM_REQ; go to IDLE.
  - m_rsp_data and m_rsp_id hold their last values afterwards; m_rsp_vld returns to 0.
- Latency:
  - Read with mem_req_rdy=1 and response one cycle after acceptance: accept in cycle 0, m_rsp_vld in cycle 3.
  - Write: mem_req_vld is first asserted in cycle 1.
- Boundary conditions:
  - Requests arriving while busy are not accepted; lsu_req_rdy stays 0.
  - A requester deasserting vld before grant is simply skipped.
  - All ports asserting continuously are served in order rr_ptr, rr_ptr+1, … (fair).
  - rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
MEM_RSP_TIMEOUT_EN
- Defined:
  - Adds a cycle counter that clears on entry to WAIT and increments each WAIT cycle without mem_rsp_vld.
  - When the counter equals TIMEOUT_CYCLES-1 and no response arrives, go to RESP with m_rsp_data = all ones.
  - Adds output port m_rsp_err (1 bit), asserted together with that m_rsp_vld pulse.
  - m_rsp_err is 0 on every normal response and after reset.
- Undefined: no counter and no m_rsp_err port; WAIT waits indefinitely.

Decomposition:
- constants_pkg (existing) provides DATA_WIDTH and ADDR_WIDTH.
- Add to constants_pkg: a mem_ctrl_state_t enum (IDLE, ISSUE, WAIT, RESP) and a constant MEM_TIMEOUT_DEFAULT = 64.
- Sub-module rr_arbiter(NUM_REQ): inputs req vector and rr_ptr; outputs one-hot grant, grant index and any_req. Purely combinational.

Test Plan:
- Single read: port 2 issues a read of addr 0x10; mem_req_rdy=1; memory returns 0xA5 one cycle after acceptance -> lsu_req_rdy=4'b0100 in cycle 0; mem_req_addr=0x10 in cycle 1; m_rsp_vld=1 with data 0xA5 and id 2 in cycle 3 only.
- Round-robin fairness: all 4 ports hold reads continuously starting with rr_ptr=0 -> four consecutive m_rsp_id values 0,1,2,3, then 0; no port starved.
- Write with backpressure: port 1 writes 0x3C to addr 0x20; mem_req_rdy held low for 3 cycles -> mem_req_vld and fields stay stable for 4 cycles; no m_rsp_vld; busy drops the cycle after acceptance.
- Spurious response and mid-operation reset: mem_rsp_vld pulsed in IDLE gives no m_rsp_vld. Reset asserted in WAIT gives state IDLE and all outputs 0 on the next edge; a later mem_rsp_vld is ignored.
- Timeout (MEM_RSP_TIMEOUT_EN, TIMEOUT_CYCLES=64): read issued, no response -> m_rsp_vld=1 with m_rsp_err=1 and data 0xFF exactly 64 cycles after entering WAIT. Without the macro, the controller stays busy indefinitely.

Source files
------------

// File: rtl/constants_pkg.sv
// constants_pkg: shared widths plus the memory-request controller state encoding and defaults.
// Revision 1.1
`default_nettype none

package constants_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 8;

  localparam int MEM_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mem_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, first set request at or above rr_ptr_i, wrapping.
// Revision 1.0
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               any_req_o
);

  logic [ID_W-1:0] idx;

  // NUM_REQ is a power of two, so the ID_W-bit add wraps modulo NUM_REQ for free.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_req_o = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_ptr_i + ID_W'(k);
      if (!any_req_o && req_i[idx]) begin
        any_req_o = 1'b1;
        gnt_idx_o = idx;
      end
    end
    if (any_req_o) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: round-robin LSU arbitration, one outstanding memory request, single-cycle response pulse.
// Optional MEM_RSP_TIMEOUT_EN adds a response watchdog and the m_rsp_err port. Revision 1.0
`default_nettype none

module mem_req_ctrl
  import constants_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ),
  parameter int DATA_WIDTH = constants_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = constants_pkg::ADDR_WIDTH
`ifdef MEM_RSP_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         lsu_req_vld,
  input  logic [NUM_REQ-1:0]         lsu_req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] lsu_req_wdata,
  output logic [NUM_REQ-1:0]         lsu_req_rdy,
  output logic                       mem_req_vld,
  output logic                       mem_req_we,
  output logic [ADDR_WIDTH-1:0]      mem_req_addr,
  output logic [DATA_WIDTH-1:0]      mem_req_wdata,
  input  logic                       mem_req_rdy,
  input  logic                       mem_rsp_vld,
  input  logic [DATA_WIDTH-1:0]      mem_rsp_data,
  output logic                       m_rsp_vld,
  output logic [DATA_WIDTH-1:0]      m_rsp_data,
  output logic [ID_W-1:0]            m_rsp_id,
`ifdef MEM_RSP_TIMEOUT_EN
  output logic                       m_rsp_err,
`endif
  output logic                       busy
);

  mem_ctrl_state_t       state_q;
  logic [ID_W-1:0]       rr_ptr_q;
  logic [ID_W-1:0]       rr_ptr_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ID_W-1:0]       id_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [ID_W-1:0]       rsp_id_q;

  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic                  any_req;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = lsu_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = lsu_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i     (lsu_req_vld),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_req_o (any_req)
  );

  assign rr_ptr_d = id_q + ID_W'(1);

`ifdef MEM_RSP_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
`ifdef MEM_RSP_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            we_q    <= lsu_req_we[gnt_idx];
            addr_q  <= addr_arr[gnt_idx];
            wdata_q <= wdata_arr[gnt_idx];
            id_q    <= gnt_idx;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_rdy) begin
            if (we_q) begin
              rr_ptr_q <= rr_ptr_d;
              state_q  <= IDLE;
            end else begin
              state_q  <= WAIT;
`ifdef MEM_RSP_TIMEOUT_EN
              cnt_q    <= '0;
`endif
            end
          end
        end
        WAIT: begin
          if (mem_rsp_vld) begin
            rsp_data_q <= mem_rsp_data;
            rsp_id_q   <= id_q;
            state_q    <= RESP;
`ifdef MEM_RSP_TIMEOUT_EN
            err_q      <= 1'b0;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_data_q <= '1;
            rsp_id_q   <= id_q;
            err_q      <= 1'b1;
            state_q    <= RESP;
          end else begin
            cnt_q      <= cnt_q + CNT_W'(1);
`endif
          end
        end
        RESP: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accept pulse is gated by reset so a held request is never acknowledged while being flushed.
  assign lsu_req_rdy   = (state_q == IDLE && !reset) ? gnt : '0;
  assign mem_req_vld   = (state_q == ISSUE);
  assign mem_req_we    = mem_req_vld & we_q;
  assign mem_req_addr  = mem_req_vld ? addr_q  : '0;
  assign mem_req_wdata = mem_req_vld ? wdata_q : '0;
  assign m_rsp_vld     = (state_q == RESP);
  assign m_rsp_data    = rsp_data_q;
  assign m_rsp_id      = rsp_id_q;
  assign busy          = (state_q != IDLE);
`ifdef MEM_RSP_TIMEOUT_EN
  assign m_rsp_err     = m_rsp_vld & err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed stimulus with a response scoreboard checked by an independent monitor.
// Revision 1.0
`default_nettype none

module tb_mem_req_ctrl;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] lsu_req_vld;
  logic [NR-1:0] lsu_req_we;
  logic [NR*8-1:0] lsu_req_addr;
  logic [NR*8-1:0] lsu_req_wdata;
  logic [NR-1:0] lsu_req_rdy;
  logic          mem_req_vld;
  logic          mem_req_we;
  logic [7:0]    mem_req_addr;
  logic [7:0]    mem_req_wdata;
  logic          mem_req_rdy;
  logic          mem_rsp_vld;
  logic [7:0]    mem_rsp_data;
  logic          m_rsp_vld;
  logic [7:0]    m_rsp_data;
  logic [1:0]    m_rsp_id;
  logic          busy;
`ifdef MEM_RSP_TIMEOUT_EN
  logic          m_rsp_err;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_req_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .lsu_req_vld   (lsu_req_vld),
    .lsu_req_we    (lsu_req_we),
    .lsu_req_addr  (lsu_req_addr),
    .lsu_req_wdata (lsu_req_wdata),
    .lsu_req_rdy   (lsu_req_rdy),
    .mem_req_vld   (mem_req_vld),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_rdy   (mem_req_rdy),
    .mem_rsp_vld   (mem_rsp_vld),
    .mem_rsp_data  (mem_rsp_data),
    .m_rsp_vld     (m_rsp_vld),
    .m_rsp_data    (m_rsp_data),
    .m_rsp_id      (m_rsp_id),
`ifdef MEM_RSP_TIMEOUT_EN
    .m_rsp_err     (m_rsp_err),
`endif
    .busy          (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_rsp_vld === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", {22'd0, m_rsp_id, m_rsp_data}, 32'hDEAD);
        end else begin
          e = sb_q.pop_front();
          check("rsp_id", 32'(m_rsp_id), 32'(e.id));
          check("rsp_data", 32'(m_rsp_data), 32'(e.data));
`ifdef MEM_RSP_TIMEOUT_EN
          check("rsp_err", 32'(m_rsp_err), 32'(e.err));
`endif
        end
      end
    end
  end

  initial begin
    int grants;
    int wcyc;
    logic rsp_next;
    logic [7:0] rd;
    logic done;

    reset         = 1'b1;
    lsu_req_vld   = '0;
    lsu_req_we    = '0;
    lsu_req_addr  = '0;
    lsu_req_wdata = '0;
    mem_req_rdy   = 1'b0;
    mem_rsp_vld   = 1'b0;
    mem_rsp_data  = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_outs", {12'd0, lsu_req_rdy, mem_req_vld, mem_req_we, mem_req_addr, mem_req_wdata, m_rsp_vld},
          32'd0);
    check("rst_rsp", {22'd0, m_rsp_id, m_rsp_data}, 32'd0);

    // Single read from port 2
    step();
    lsu_req_vld  = 4'b0100;
    lsu_req_addr = 32'h0010_0000;
    mem_req_rdy  = 1'b1;
    @(negedge clk);
    check("rd_grant", 32'(lsu_req_rdy), 32'h4);
    sb_q.push_back('{id: 2'd2, data: 8'hA5, err: 1'b0});
    step();
    lsu_req_vld = '0;
    @(negedge clk);
    check("rd_issue", {14'd0, mem_req_vld, mem_req_we, mem_req_addr, 8'h00}, {14'd0, 1'b1, 1'b0, 8'h10, 8'h00});
    step();
    mem_rsp_vld  = 1'b1;
    mem_rsp_data = 8'hA5;
    @(negedge clk);
    check("rd_c2_novld", 32'(m_rsp_vld), 0);
    step();
    mem_rsp_vld = 1'b0;
    @(negedge clk);
    check("rd_c3_vld", {21'd0, m_rsp_vld, m_rsp_id, m_rsp_data}, {21'd0, 1'b1, 2'd2, 8'hA5});
    step();
    @(negedge clk);
    check("rd_c4_hold", {21'd0, m_rsp_vld, m_rsp_id, m_rsp_data}, {21'd0, 1'b0, 2'd2, 8'hA5});
    check("rd_c4_idle", 32'(busy), 0);

    // Fairness: reset to rr_ptr=0, all ports read continuously
    reset = 1'b1;
    step();
    reset = 1'b0;
    lsu_req_addr = 32'h8382_8180;
    for (int k = 0; k < 5; k++)
      sb_q.push_back('{id: 2'(k % 4), data: (8'h80 + 8'(k % 4)) ^ 8'h5A, err: 1'b0});
    lsu_req_vld = 4'b1111;
    grants = 0;
    rd     = '0;
    done   = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      rsp_next = 1'b0;
      if (lsu_req_rdy != '0) begin
        check("rr_grant", 32'(lsu_req_rdy), 32'(1) << (grants % 4));
        grants++;
      end
      if (mem_req_vld && !mem_req_we) begin
        rsp_next = 1'b1;
        rd       = mem_req_addr ^ 8'h5A;
      end
      if (grants == 5 && sb_q.size() == 0 && !busy) done = 1'b1;
      step();
      if (grants >= 5) lsu_req_vld = '0;
      mem_rsp_vld  = rsp_next;
      mem_rsp_data = rd;
    end
    mem_rsp_vld = 1'b0;
    check("rr_complete", {31'd0, done}, 1);

    // Write from port 1 with three cycles of backpressure
    mem_req_rdy   = 1'b0;
    lsu_req_vld   = 4'b0010;
    lsu_req_we    = 4'b0010;
    lsu_req_addr  = 32'h0000_2000;
    lsu_req_wdata = 32'h0000_3C00;
    @(negedge clk);
    check("wr_grant", 32'(lsu_req_rdy), 32'h2);
    step();
    lsu_req_vld = '0;
    lsu_req_we  = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_req_rdy = 1'b1;
      @(negedge clk);
      check("wr_hold", {14'd0, mem_req_vld, mem_req_we, mem_req_addr, mem_req_wdata},
            {14'd0, 1'b1, 1'b1, 8'h20, 8'h3C});
      step();
    end
    mem_req_rdy = 1'b0;
    @(negedge clk);
    check("wr_done", {30'd0, busy, mem_req_vld}, 0);

    // Spurious response in IDLE
    step();
    mem_rsp_vld  = 1'b1;
    mem_rsp_data = 8'h99;
    step();
    mem_rsp_vld = 1'b0;
    @(negedge clk);
    check("spur_novld", {30'd0, m_rsp_vld, busy}, 0);

    // Reset while in WAIT, then a late response
    lsu_req_vld  = 4'b1000;
    lsu_req_addr = 32'h4400_0000;
    mem_req_rdy  = 1'b1;
    step();
    lsu_req_vld = '0;
    step();
    @(negedge clk);
    check("mid_wait_busy", {30'd0, busy, mem_req_vld}, 32'h2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_outs", {11'd0, busy, lsu_req_rdy, mem_req_vld, mem_req_we, mem_req_addr, mem_req_wdata, m_rsp_vld},
          32'd0);
    check("mid_rst_rsp", {22'd0, m_rsp_id, m_rsp_data}, 32'd0);
    mem_rsp_vld  = 1'b1;
    mem_rsp_data = 8'h77;
    step();
    mem_rsp_vld = 1'b0;
    @(negedge clk);
    check("late_rsp_ign", {30'd0, m_rsp_vld, busy}, 0);

    // Read that never gets a response
    lsu_req_vld  = 4'b0001;
    lsu_req_addr = 32'h0000_0055;
    mem_req_rdy  = 1'b1;
    step();
    lsu_req_vld = '0;
    step();
    mem_req_rdy = 1'b0;
`ifdef MEM_RSP_TIMEOUT_EN
    sb_q.push_back('{id: 2'd0, data: 8'hFF, err: 1'b1});
    wcyc = -1;
    for (int c = 0; c < 200 && wcyc < 0; c++) begin
      @(negedge clk);
      if (m_rsp_vld) wcyc = c;
      step();
    end
    check("timeout_cycles", 32'(wcyc), 64);
`else
    wcyc = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy && !m_rsp_vld) wcyc++;
      step();
    end
    check("no_timeout_busy", 32'(wcyc), 100);
    reset = 1'b1;
    step();
    reset = 1'b0;
`endif

    step();
    step();
    @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 0);
    check("final_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
